// File: rtl/cnt_div_ctrl.sv
// Start/Stop/Hold run-control for a prescaled up-counter with terminal pulse.
// Define CNT_CTRL_AUTORELOAD_EN to let Reload restart the count at terminal.
module cnt_div_ctrl #(
    parameter int PRE_W = 18,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             RST_N,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Hold,
    input  logic [CNT_W-1:0] Cmp_Val,
    input  logic             Reload,
    output logic [CNT_W-1:0] Cnt_Out,
    output logic             Done,
    output logic             Busy,
    output logic [1:0]       State
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    logic             idle_or_done;
    logic             active;
    logic             tick;
    logic             term;

    assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
    assign active       = (state_q == S_RUN) || (state_q == S_PAUSE);
    assign tick         = &pre_q;
    assign term         = (cnt_q == cmp_q);

`ifndef CNT_CTRL_AUTORELOAD_EN
    logic unused_reload;
    assign unused_reload = Reload;
`endif

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        cmp_d   = cmp_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (Stop) begin
            state_d = S_IDLE;
            pre_d   = '0;
            cnt_d   = '0;
        end else if (Start && idle_or_done) begin
            state_d = S_RUN;
            cmp_d   = Cmp_Val;
            pre_d   = '0;
            cnt_d   = '0;
        end else if (active && Hold) begin
            state_d = S_PAUSE;
        end else if (active) begin
            // Leaving PAUSE advances in the same edge, so a hold costs one clock per cycle held.
            state_d = S_RUN;
            pre_d   = pre_q + 1'b1;
            if (tick) begin
                if (!term) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    done_d = 1'b1;
`ifdef CNT_CTRL_AUTORELOAD_EN
                    if (Reload) begin
                        cnt_d = '0;
                    end else begin
                        state_d = S_DONE;
                    end
`else
                    state_d = S_DONE;
`endif
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            cmp_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            cmp_q   <= cmp_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign Cnt_Out = cnt_q;
    assign Done    = done_q;
    assign State   = state_q;
    assign Busy    = active;

endmodule
